relu_pool_stream: RTL
=====================

Name: relu_pool_stream

Overview:
- Downstream consumer of the SparseCNN top-level output.
- Captures one flattened output_size x output_size frame of signed double-word convolution results (the out_valid / out_feature pair).
- Applies ReLU, then 2x2 stride-2 max-pooling.
- Streams the pooled map one word per handshake, row-major, over a valid/ready interface toward the next layer or the host.

Parameters:
- output_size, 24, rows/cols of the square input frame (pooled map is output_size/2, floor)
- double_word_length, 16, bit width of each signed frame element and output word
- coord_length, 8, width of the emitted row/col coordinates

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  frame valid; level, may stay high for many cycles
- in_feature  input  output_size*output_size*double_word_length  frame; element (r,c) at bits [(r*output_size+c)*double_word_length +: double_word_length], two's complement
- in_ready  output  1  high only in IDLE
- out_valid  output  1  pooled word valid
- out_ready  input  1  downstream accept
- out_data  output  double_word_length  pooled word (non-negative)
- out_row  output  coord_length  pooled row index pr
- out_col  output  coord_length  pooled col index pc
- out_last  output  1  high with the final word, (P-1,P-1), where P = output_size/2
- busy  output  1  high in STREAM or WAIT_LOW

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, busy=0. Frame register cleared; state IDLE.
- States:
  - IDLE: in_ready=1. On in_valid=1, latch in_feature into the frame register at the same edge, clear pr/pc, go to STREAM.
  - STREAM: out_valid=1. Presents pooled word (pr,pc).
    - On out_valid && out_ready, advance pc; when pc wraps to 0, advance pr.
    - Next word is valid the very next cycle: one word per cycle at full throughput, no bubbles.
    - On handshake of the last word: go to IDLE if in_valid=0 is sampled that edge, else go to WAIT_LOW.
  - WAIT_LOW: out_valid=0, in_ready=0. Return to IDLE on the first edge where in_valid=0. This prevents re-capturing a frame whose valid level is still held high.
- Latency: frame accepted at edge k; out_valid=1 with word (0,0) after edge k. Complete frame takes P*P cycles when out_ready is held high.
- Pooled word (pr,pc):
  - max over ReLU(x) of elements (2pr,2pc), (2pr,2pc+1), (2pr+1,2pc), (2pr+1,2pc+1).
  - ReLU(x) = 0 if the sign bit is set, else x. Comparisons are unsigned after ReLU. Output is never negative.
  - out_data is computed combinationally from the frame register and the registered pr/pc. out_row/out_col equal pr/pc.
- Stall: while out_valid=1 and out_ready=0, out_data/out_row/out_col/out_last hold stable. The frame register is not modified.
- The frame register is written only in IDLE. in_feature changes during STREAM/WAIT_LOW are ignored.
- Odd output_size: the last input row and column are dropped (P = floor). output_size=1 yields P=0: the frame is accepted, nothing is emitted, go straight to the IDLE/WAIT_LOW rule.
- Async reset mid-STREAM aborts the frame immediately. No partial output after release.
- out_ready high outside STREAM has no effect.

Optional Feature:
- Macro POOL_AVG_EN.
- Defined: average pooling instead of max.
  - Sum the four ReLU values at double_word_length+2 bits, then shift right by 2 (truncate toward zero).
  - Result fits double_word_length bits.
  - Handshake, ordering and latency are unchanged.
- Undefined: max pooling as above.

Test Plan:
- All elements = +5 with out_ready held 1 -> 144 words of 5 on consecutive cycles; out_last only on (11,11); busy drops after the last handshake.
- Frame with element(r,c) = r*24+c -> word (pr,pc) = (2pr+1)*24+2pc+1; e.g. (0,0)=25, (11,11)=575. Order is row-major.
- Quad (0,0) = {-3, 7, -100, 2} (0x8000 included in another quad) -> (0,0)=7; an all-negative quad -> 0. With POOL_AVG_EN, quad {-3,7,-100,2} -> (0+7+0+2)>>2 = 2.
- out_ready toggled pseudo-randomly, 1 cycle in 3 -> outputs stable during stalls; exactly 144 handshakes; no duplicates or skips.
- in_valid held high for 500 cycles -> exactly one frame streamed; stays in WAIT_LOW until in_valid=0; a second pulse then streams a new frame.
- rst asserted during word (4,7) -> all outputs take reset values asynchronously; after release, a new frame starts at (0,0).

Source files
------------

// File: rtl/relu_pool_stream.sv
// relu_pool_stream: captures a signed frame, applies ReLU and 2x2 stride-2 pooling, streams the pooled map row-major.
// Define POOL_AVG_EN to average the four ReLU values instead of taking their maximum.
module relu_pool_stream #(
  parameter int output_size = 24,
  parameter int double_word_length = 16,
  parameter int coord_length = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic [output_size*output_size*double_word_length-1:0] in_feature,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic [double_word_length-1:0] out_data,
  output logic [coord_length-1:0] out_row,
  output logic [coord_length-1:0] out_col,
  output logic out_last,
  output logic busy
);
  localparam int dw = double_word_length;
  localparam int p = output_size / 2;
  localparam logic [coord_length-1:0] last_idx = coord_length'(p > 0 ? p - 1 : 0);
  localparam logic [1:0] s_idle = 2'd0, s_stream = 2'd1, s_wait_low = 2'd2;
  logic [1:0] state_q, state_d;
  logic [output_size*output_size*dw-1:0] frame_q;
  logic [coord_length-1:0] pr_q, pr_d, pc_q, pc_d;
  logic [dw-1:0] q [4];
  logic [dw-1:0] pooled;
  logic fire, at_last;
  function automatic logic [dw-1:0] relu(input logic [dw-1:0] x);
    return x[dw-1] ? '0 : x;
  endfunction
  assign in_ready = state_q == s_idle;
  assign out_valid = state_q == s_stream;
  assign busy = state_q != s_idle;
  assign out_row = pr_q;
  assign out_col = pc_q;
  assign at_last = pr_q == last_idx && pc_q == last_idx;
  assign out_last = out_valid && at_last;
  assign fire = out_valid && out_ready;
  assign out_data = out_valid ? pooled : '0;
  // Quad element i sits at row 2pr + i/2, col 2pc + i%2.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      q[i] = relu(frame_q[((2 * int'(pr_q) + i / 2) * output_size + 2 * int'(pc_q) + i % 2) * dw +: dw]);
    end
  end
`ifdef POOL_AVG_EN
  logic [dw+1:0] sum;
  always_comb begin
    sum = {2'b00, q[0]} + {2'b00, q[1]} + {2'b00, q[2]} + {2'b00, q[3]};
    pooled = sum[dw+1:2];
  end
`else
  logic [dw-1:0] m01, m23;
  always_comb begin
    m01 = q[0] > q[1] ? q[0] : q[1];
    m23 = q[2] > q[3] ? q[2] : q[3];
    pooled = m01 > m23 ? m01 : m23;
  end
`endif
  always_comb begin
    state_d = state_q;
    pr_d = pr_q;
    pc_d = pc_q;
    if (state_q == s_idle) begin
      if (in_valid) begin
        pr_d = '0;
        pc_d = '0;
        state_d = p == 0 ? s_wait_low : s_stream;
      end
    end else if (state_q == s_stream) begin
      if (fire) begin
        pc_d = pc_q == last_idx ? '0 : pc_q + 1'b1;
        pr_d = pc_q != last_idx ? pr_q : at_last ? '0 : pr_q + 1'b1;
        if (at_last) state_d = in_valid ? s_wait_low : s_idle;
      end
    end else if (!in_valid) begin
      state_d = s_idle;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= s_idle;
      frame_q <= '0;
      pr_q <= '0;
      pc_q <= '0;
    end else begin
      state_q <= state_d;
      pr_q <= pr_d;
      pc_q <= pc_d;
      if (state_q == s_idle && in_valid) frame_q <= in_feature;
    end
  end
endmodule
